rptr_rempty_fwft: RTL and testbench

Read-domain controller of the async FIFO, the counterpart of the write-pointer/full stage. It consumes the write pointer after it has been synchronised into the read domain and generates the read address, the Gray read pointer (fed back to the write domain), registered empty and almost-empty flags, and memory read enable. It also contains a 2-entry first-word-fall-through output stage that hides the 1-cycle synchronous memory read latency behind a valid/ready stream interface.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_out_skid.sv | 92 +++++++++
 rtl/rptr_rempty_fwft.sv | 109 ++++++++++
 tb/tb_rptr_rempty_fwft.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read and write domain controllers.
//   - Default address and data widths.
//   - Binary/Gray conversion helpers. They operate on a 32-bit container; the
//     caller zero-extends a narrower pointer and keeps the low AWIDTH+1 bits.
//     Zero-extension does not change either result in the low bits.
//   - Encoding of the occupancy of the read-side output stage.
package fifo_pkg;

  localparam int unsigned AWIDTH_DEF = 3;
  localparam int unsigned DWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OS_EMPTY = 2'd0,
    OS_ONE   = 2'd1,
    OS_TWO   = 2'd2
  } os_count_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry first-word-fall-through output stage of the FIFO read side.
// A synchronous memory returns data one cycle after its read enable; this stage
// captures that data and presents it on a valid/ready stream.
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   mem_vld_i       rdata_i carries a word read in the previous cycle
//   rdata_i         memory read data
//   dout_ready_i    consumer accepts dout_o
//   dout_o          oldest held word (registered)
//   dout_valid_o    dout_o holds a word (registered)
//   count_o         words held (0..2), used by the upstream credit rule
module fifo_out_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_vld_i,
  input  logic [DWIDTH-1:0] rdata_i,
  input  logic              dout_ready_i,
  output logic [DWIDTH-1:0] dout_o,
  output logic              dout_valid_o,
  output logic [1:0]        count_o
);

  os_count_e         count_q, count_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic [DWIDTH-1:0] skid_q, skid_d;
  logic              dout_valid_q;
  logic              pop;

  // Ready is ignored while nothing is held.
  assign pop = dout_valid_q & dout_ready_i;

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    skid_d  = skid_q;
    unique case (count_q)
      OS_EMPTY: begin
        if (mem_vld_i) begin
          dout_d  = rdata_i;
          count_d = OS_ONE;
        end
      end
      OS_ONE: begin
        if (mem_vld_i && !pop) begin
          skid_d  = rdata_i;
          count_d = OS_TWO;
        end else if (!mem_vld_i && pop) begin
          count_d = OS_EMPTY;
        end else if (mem_vld_i && pop) begin
          dout_d = rdata_i;
        end
      end
      OS_TWO: begin
        // A new word while full and not popping is excluded by the credit rule.
        if (pop) begin
          dout_d = skid_q;
          if (mem_vld_i) begin
            skid_d = rdata_i;
          end else begin
            count_d = OS_ONE;
          end
        end
      end
      default: count_d = OS_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= OS_EMPTY;
      dout_q       <= '0;
      skid_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      skid_q       <= skid_d;
      dout_valid_q <= (count_d != OS_EMPTY);
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign count_o      = count_q;

  overrun_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(count_q == OS_TWO && mem_vld_i && !pop));

endmodule

// File: rtl/rptr_rempty_fwft.sv
// Read-domain controller of the async FIFO.
// Tracks the read pointer against the synchronised write pointer, produces
// registered empty / almost-empty flags, drives the memory read port and hides
// the one-cycle memory latency behind a first-word-fall-through stream.
//   rclk, rrst_n   read clock and asynchronous active-low reset
//   wptr_sync      Gray write pointer already synchronised into rclk
//   rdata_mem      memory read data, valid one cycle after ren
//   raddr          memory read address
//   ren            memory read enable (combinational)
//   rptr           registered Gray read pointer for the write domain
//   rempty         registered memory-empty flag
//   raempty        registered almost-empty flag (level <= AEMPTY_THR)
//   dout           head-of-stream data (registered)
//   dout_valid     dout holds a word
//   dout_ready     consumer accepts dout
module rptr_rempty_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH     = AWIDTH_DEF,
  parameter int unsigned DWIDTH     = DWIDTH_DEF,
  parameter int unsigned AEMPTY_THR = 1
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [AWIDTH:0]   wptr_sync,
  input  logic [DWIDTH-1:0] rdata_mem,
  output logic [AWIDTH-1:0] raddr,
  output logic              ren,
  output logic [AWIDTH:0]   rptr,
  output logic              rempty,
  output logic              raempty,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  localparam int unsigned PW = AWIDTH + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic          mem_vld_q;

  logic [31:0]   rgnext_w, wbin_w;
  logic [PW-1:0] wbin, level;
  logic [1:0]    os_count;
  logic [2:0]    occupancy;
  logic          pop;
  logic          ren_w;
  logic          unused_hi;

  assign pop = dout_valid & dout_ready;

  // Words the output stage will hold after this edge, counting the one in flight.
  // A read is issued only if that leaves room for its data next cycle.
  assign occupancy = {1'b0, os_count} + {2'b00, mem_vld_q} - {2'b00, pop};
  assign ren_w     = ~rempty_q & (occupancy < 3'd2);

  always_comb begin
    rbin_d    = rbin_q + {{AWIDTH{1'b0}}, ren_w};
    rgnext_w  = bin2gray(32'(rbin_d));
    rptr_d    = rgnext_w[PW-1:0];
    // Gray equality stays exact across the pointer wrap.
    rempty_d  = (rptr_d == wptr_sync);
    wbin_w    = gray2bin(32'(wptr_sync));
    wbin      = wbin_w[PW-1:0];
    level     = wbin - rbin_d;
    raempty_d = (32'(level) <= AEMPTY_THR);
  end

  assign unused_hi = ^{rgnext_w[31:PW], wbin_w[31:PW]};

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      mem_vld_q <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      mem_vld_q <= ren_w;
    end
  end

  fifo_out_skid #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk_i       (rclk),
    .rst_ni      (rrst_n),
    .mem_vld_i   (mem_vld_q),
    .rdata_i     (rdata_mem),
    .dout_ready_i(dout_ready),
    .dout_o      (dout),
    .dout_valid_o(dout_valid),
    .count_o     (os_count)
  );

  assign raddr   = rbin_q[AWIDTH-1:0];
  assign ren     = ren_w;
  assign rptr    = rptr_q;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;

endmodule

// File: tb/tb_rptr_rempty_fwft.sv
module tb_rptr_rempty_fwft;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [3:0] wptr_sync;
  logic [7:0] rdata_mem;
  logic [2:0] raddr;
  logic       ren;
  logic [3:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mem[8];
  int         wcnt;
  int         rd_cnt;
  logic [3:0] prev_wb;
  logic [3:0] mon_rc;
  logic [3:0] mon_lvl;
  logic [7:0] mon_exp;
  bit         mon_en = 1'b0;

  rptr_rempty_fwft #(
    .AWIDTH    (3),
    .DWIDTH    (8),
    .AEMPTY_THR(1)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .wptr_sync (wptr_sync),
    .rdata_mem (rdata_mem),
    .raddr     (raddr),
    .ren       (ren),
    .rptr      (rptr),
    .rempty    (rempty),
    .raempty   (raempty),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  always #5 rclk = ~rclk;

  // Synchronous memory: data for ren appears after the edge; junk otherwise.
  always @(posedge rclk) begin
    if (ren) rdata_mem <= mem[raddr];
    else     rdata_mem <= 8'($urandom);
  end

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  function automatic logic [3:0] from_gray(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // Per-cycle flag/pointer model and scoreboard pop side.
  always @(negedge rclk) begin
    if (mon_en && rrst_n) begin
      mon_rc  = rd_cnt[3:0];
      mon_lvl = prev_wb - mon_rc;
      n_checks++;
      if (rempty !== (mon_rc == prev_wb)) begin
        n_fail++;
        $display("FAIL rempty @%0t: got %b expected %b", $time, rempty, (mon_rc == prev_wb));
      end
      n_checks++;
      if (raempty !== (mon_lvl <= 4'd1)) begin
        n_fail++;
        $display("FAIL raempty @%0t: got %b expected %b", $time, raempty, (mon_lvl <= 4'd1));
      end
      n_checks++;
      if (rptr !== to_gray(mon_rc)) begin
        n_fail++;
        $display("FAIL rptr @%0t: got %h expected %h", $time, rptr, to_gray(mon_rc));
      end
      if (ren) begin
        n_checks++;
        if (raddr !== mon_rc[2:0] || rempty) begin
          n_fail++;
          $display("FAIL read_issue @%0t: raddr %0d rempty %b expected raddr %0d rempty 0",
                   $time, raddr, rempty, mon_rc[2:0]);
        end
        rd_cnt++;
      end
      if (dout_valid && dout_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra @%0t: got word %h expected none", $time, dout);
        end else begin
          mon_exp = exp_q.pop_front();
          if (dout !== mon_exp) begin
            n_fail++;
            $display("FAIL stream_data @%0t: got %h expected %h", $time, dout, mon_exp);
          end
        end
      end
      prev_wb = from_gray(wptr_sync);
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge rclk);
  endtask

  // Write-side model: store words, queue expectations, publish the new pointer.
  task automatic write_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wcnt % 8] = 8'(base + 8'(i));
      exp_q.push_back(8'(base + 8'(i)));
      wcnt++;
    end
    wptr_sync = to_gray(wcnt[3:0]);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    // Used only for one-bit point checks inside the scenario tasks below.
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  task automatic test_reset();
    mon_en     = 1'b0;
    rrst_n     = 1'b0;
    wptr_sync  = '0;
    dout_ready = 1'b0;
    wcnt       = 0;
    rd_cnt     = 0;
    prev_wb    = '0;
    exp_q.delete();
    repeat (3) tick();
    rrst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      n_checks++;
      if ({rempty, raempty, ren, dout_valid, rptr} !== {4'b1100, 4'h0}) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got e/ae/ren/v/rptr %b%b%b%b/%h expected 1100/0",
                 i, rempty, raempty, ren, dout_valid, rptr);
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    tick();
    dout_ready = 1'b0;
    write_words(1, 8'hA5);
    at_neg();
    check_bit("single_pre_empty", rempty, 1'b1);
    at_neg();
    check_bit("single_e1_rempty", rempty, 1'b0);
    check_bit("single_e1_ren", ren, 1'b1);
    check_bit("single_e1_valid", dout_valid, 1'b0);
    at_neg();
    check_bit("single_e2_ren", ren, 1'b0);
    check_bit("single_e2_rempty", rempty, 1'b1);
    check_bit("single_e2_valid", dout_valid, 1'b0);
    n_checks++;
    if (rptr !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_rptr: got %b expected 0001", rptr);
    end
    for (int i = 0; i < 2; i++) begin
      at_neg();
      check_bit("single_e3_valid", dout_valid, 1'b1);
      n_checks++;
      if (dout !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_dout: got %h expected a5", dout);
      end
    end
    tick();
    dout_ready = 1'b1;
    tick();
    at_neg();
    check_bit("single_drained", dout_valid, 1'b0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_left: got %0d words pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_fill_ready();
    int  nv;
    bit  started;
    bit  ended;
    bit  gap;
    nv = 0; started = 0; ended = 0; gap = 0;
    tick();
    dout_ready = 1'b1;
    write_words(8, 8'h10);
    for (int i = 0; i < 30; i++) begin
      at_neg();
      if (dout_valid) begin
        if (ended) gap = 1;
        started = 1;
        nv++;
      end else if (started) begin
        ended = 1;
      end
    end
    n_checks++;
    if (nv != 8 || gap) begin
      n_fail++;
      $display("FAIL fill_ready_burst: got %0d valid cycles gap %b expected 8 gap 0", nv, gap);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_ready_left: got %0d pending expected 0", exp_q.size());
    end
    check_bit("fill_ready_raempty", raempty, 1'b1);
  endtask

  task automatic test_fill_stall();
    int s;
    tick();
    dout_ready = 1'b0;
    s = rd_cnt;
    write_words(8, 8'h40);
    repeat (12) at_neg();
    n_checks++;
    if (rd_cnt - s != 2) begin
      n_fail++;
      $display("FAIL stall_reads: got %0d reads expected 2", rd_cnt - s);
    end
    check_bit("stall_ren", ren, 1'b0);
    check_bit("stall_valid", dout_valid, 1'b1);
    n_checks++;
    if (dout !== 8'h40) begin
      n_fail++;
      $display("FAIL stall_head: got %h expected 40", dout);
    end
    tick();
    dout_ready = 1'b1;
    repeat (20) at_neg();
    n_checks++;
    if (exp_q.size() != 0 || rd_cnt - s != 8) begin
      n_fail++;
      $display("FAIL stall_release: got %0d pending %0d reads expected 0 pending 8 reads",
               exp_q.size(), rd_cnt - s);
    end
    check_bit("stall_done_valid", dout_valid, 1'b0);
  endtask

  task automatic test_wrap();
    int  written;
    int  chunk;
    int  s;
    bit  done;
    written = 0;
    done    = 0;
    s       = rd_cnt;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      dout_ready = 1'($urandom_range(0, 1));
      if (written < 20) begin
        chunk = $urandom_range(1, 3);
        if (chunk > 20 - written) chunk = 20 - written;
        if (wcnt - rd_cnt + chunk <= 8) begin
          write_words(chunk, 8'(8'h80 + 8'(written)));
          written += chunk;
        end
      end else if (exp_q.size() == 0) begin
        done = 1;
      end
    end
    n_checks++;
    if (!done || rd_cnt - s != 20) begin
      n_fail++;
      $display("FAIL wrap_stream: got done %b reads %0d expected done 1 reads 20",
               done, rd_cnt - s);
    end
    at_neg();
    check_bit("wrap_empty", rempty, 1'b1);
    check_bit("wrap_valid", dout_valid, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    tick();
    dout_ready = 1'b0;
    write_words(4, 8'hC0);
    for (int i = 0; i < 10 && !seen; i++) begin
      at_neg();
      if (dout_valid) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_fill: got no valid word expected one within 10 cycles");
    end
    // One word held, the next still in flight from memory.
    #2;
    mon_en = 1'b0;
    rrst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout_valid, rempty, raempty, ren, rptr, dout} !== {4'b0110, 4'h0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got v/e/ae/ren/rptr/dout %b%b%b%b/%h/%h expected 0110/0/00",
               dout_valid, rempty, raempty, ren, rptr, dout);
    end
    wptr_sync = '0;
    wcnt      = 0;
    rd_cnt    = 0;
    prev_wb   = '0;
    exp_q.delete();
    repeat (2) tick();
    rrst_n     = 1'b1;
    dout_ready = 1'b1;
    mon_en     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      check_bit("mid_no_stale", dout_valid, 1'b0);
    end
    tick();
    write_words(1, 8'h3C);
    repeat (6) at_neg();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_restart: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_ready();
    test_fill_stall();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
